// File: rtl/snake_pkg.sv
// Shared encodings and grid limits for the snake autopilot.
// Wall avoidance is compiled in with AUTOPILOT_WALL_EN.
package snake_pkg;

  localparam int GRID_X_MAX   = 79;
  localparam int GRID_Y_MAX   = 59;
  localparam int PULSE_CYCLES = 2;
  localparam int HOLD_TIKS    = 2;

  typedef enum logic [1:0] {
    DIR_UP,
    DIR_DOWN,
    DIR_LEFT,
    DIR_RIGHT
  } dir_e;

  typedef enum logic [1:0] {
    TURN_NONE,
    TURN_CW,
    TURN_CCW
  } turn_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TIK,
    ST_DECIDE,
    ST_PULSE,
    ST_HOLD
  } state_e;

  function automatic logic onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/snake_autopilot_decide.sv
// Combinational turn chooser: heading {up,down,left,right} plus fruit offset -> turn.
// AUTOPILOT_WALL_EN adds a wall-avoidance override.
module snake_autopilot_decide
  import snake_pkg::*;
(
  input  logic [3:0] heading,
  input  logic [7:0] dx,
  input  logic [7:0] dy,
  input  logic [6:0] head_x,
  input  logic [6:0] head_y,
  output logic [1:0] turn
);

  dir_e              dir;
  logic              valid;
  logic signed [7:0] fwd;
  logic signed [7:0] lat;
  turn_e             fruit_turn;

  always_comb begin
    valid = onehot4(heading);
    dir   = DIR_RIGHT;
    if (valid) begin
      unique case (1'b1)
        heading[3]: dir = DIR_UP;
        heading[2]: dir = DIR_DOWN;
        heading[1]: dir = DIR_LEFT;
        default:    dir = DIR_RIGHT;
      endcase
    end
  end

  // fwd: progress along heading; lat: offset toward the clockwise side
  always_comb begin
    fwd = $signed(dx);
    lat = $signed(dy);
    unique case (dir)
      DIR_LEFT: begin
        fwd = -$signed(dx);
        lat = -$signed(dy);
      end
      DIR_UP: begin
        fwd = -$signed(dy);
        lat = $signed(dx);
      end
      DIR_DOWN: begin
        fwd = $signed(dy);
        lat = -$signed(dx);
      end
      default: begin
        fwd = $signed(dx);
        lat = $signed(dy);
      end
    endcase
  end

  always_comb begin
    fruit_turn = TURN_NONE;
    if (!valid)        fruit_turn = TURN_NONE;
    else if (fwd > 0)  fruit_turn = TURN_NONE;
    else if (lat > 0)  fruit_turn = TURN_CW;
    else if (lat < 0)  fruit_turn = TURN_CCW;
    else if (fwd == 0) fruit_turn = TURN_NONE;
    else               fruit_turn = TURN_CW;
  end

`ifdef AUTOPILOT_WALL_EN
  logic       at_wall;
  logic [6:0] cw_room;
  logic [6:0] ccw_room;

  always_comb begin
    at_wall  = 1'b0;
    cw_room  = 7'd0;
    ccw_room = 7'd0;
    unique case (dir)
      DIR_RIGHT: begin
        at_wall  = head_x == 7'(GRID_X_MAX);
        cw_room  = 7'(GRID_Y_MAX) - head_y;
        ccw_room = head_y;
      end
      DIR_LEFT: begin
        at_wall  = head_x == 7'd0;
        cw_room  = head_y;
        ccw_room = 7'(GRID_Y_MAX) - head_y;
      end
      DIR_UP: begin
        at_wall  = head_y == 7'd0;
        cw_room  = 7'(GRID_X_MAX) - head_x;
        ccw_room = head_x;
      end
      default: begin
        at_wall  = head_y == 7'(GRID_Y_MAX);
        cw_room  = head_x;
        ccw_room = 7'(GRID_X_MAX) - head_x;
      end
    endcase
  end

  always_comb begin
    turn = fruit_turn;
    if (valid && at_wall)
      turn = (cw_room >= ccw_room) ? TURN_CW : TURN_CCW;
  end
`else
  logic unused_head;
  assign unused_head = ^{head_x, head_y};

  always_comb begin
    turn = fruit_turn;
  end
`endif

endmodule

// File: rtl/snake_autopilot.sv
// Attract-mode steering: one turn decision per game_tik, emitted as button pulses.
// AUTOPILOT_WALL_EN enables wall avoidance in the decide block.
module snake_autopilot
  import snake_pkg::*;
(
  input  logic       clock_25,
  input  logic       reset,
  input  logic       enable,
  input  logic       game_tik,
  input  logic [6:0] snake_head_x,
  input  logic [6:0] snake_head_y,
  input  logic [6:0] fruit_x,
  input  logic [6:0] fruit_y,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  output logic       right_P,
  output logic       left_P,
  output logic       busy,
  output logic       missed
);

  localparam int PCW = $clog2(PULSE_CYCLES + 1);
  localparam int TCW = $clog2(HOLD_TIKS + 2);

  state_e     state_q, state_d;
  logic [3:0] hd_q, hd_d;
  logic [7:0] dx_q, dx_d;
  logic [7:0] dy_q, dy_d;
  logic [6:0] hx_q, hx_d;
  logic [6:0] hy_q, hy_d;
  logic [PCW-1:0] pcnt_q, pcnt_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
  logic right_q, right_d;
  logic left_q, left_d;
  logic busy_q, busy_d;
  logic missed_q, missed_d;

  logic [3:0] hd_now;
  logic [1:0] turn_w;

  assign hd_now = {up, down, left, right};

  snake_autopilot_decide u_decide (
    .heading (hd_q),
    .dx      (dx_q),
    .dy      (dy_q),
    .head_x  (hx_q),
    .head_y  (hy_q),
    .turn    (turn_w)
  );

  always_comb begin
    state_d  = state_q;
    hd_d     = hd_q;
    dx_d     = dx_q;
    dy_d     = dy_q;
    hx_d     = hx_q;
    hy_d     = hy_q;
    pcnt_d   = pcnt_q;
    tcnt_d   = tcnt_q;
    right_d  = right_q;
    left_d   = left_q;
    busy_d   = busy_q;
    missed_d = missed_q;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_TIK;
      end
      ST_WAIT_TIK: begin
        if (game_tik) begin
          hd_d    = hd_now;
          dx_d    = {1'b0, fruit_x} - {1'b0, snake_head_x};
          dy_d    = {1'b0, fruit_y} - {1'b0, snake_head_y};
          hx_d    = snake_head_x;
          hy_d    = snake_head_y;
          state_d = ST_DECIDE;
        end
      end
      ST_DECIDE: begin
        pcnt_d = '0;
        tcnt_d = '0;
        if (turn_w == TURN_NONE) begin
          state_d = ST_WAIT_TIK;
        end else begin
          right_d = turn_w == TURN_CW;
          left_d  = turn_w == TURN_CCW;
          busy_d  = 1'b1;
          state_d = ST_PULSE;
        end
      end
      ST_PULSE: begin
        if (game_tik) tcnt_d = tcnt_q + 1'b1;
        if (pcnt_q == PCW'(PULSE_CYCLES - 1)) begin
          right_d = 1'b0;
          left_d  = 1'b0;
          state_d = ST_HOLD;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      ST_HOLD: begin
        if (hd_now != hd_q) begin
          busy_d  = 1'b0;
          state_d = ST_WAIT_TIK;
        end else if (game_tik) begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_q + 1'b1 >= TCW'(HOLD_TIKS)) begin
            busy_d   = 1'b0;
            missed_d = 1'b1;
            state_d  = ST_WAIT_TIK;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // dropping enable aborts everything except the sticky miss flag
    if (!enable) begin
      right_d = 1'b0;
      left_d  = 1'b0;
      busy_d  = 1'b0;
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clock_25) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      hd_q     <= '0;
      dx_q     <= '0;
      dy_q     <= '0;
      hx_q     <= '0;
      hy_q     <= '0;
      pcnt_q   <= '0;
      tcnt_q   <= '0;
      right_q  <= 1'b0;
      left_q   <= 1'b0;
      busy_q   <= 1'b0;
      missed_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      hd_q     <= hd_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      hx_q     <= hx_d;
      hy_q     <= hy_d;
      pcnt_q   <= pcnt_d;
      tcnt_q   <= tcnt_d;
      right_q  <= right_d;
      left_q   <= left_d;
      busy_q   <= busy_d;
      missed_q <= missed_d;
    end
  end

  assign right_P = right_q;
  assign left_P  = left_q;
  assign busy    = busy_q;
  assign missed  = missed_q;

endmodule
